// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundles for the fetch stage: instruction-memory read port and decode-side stream.
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

interface instr_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (output instr_valid, instruction, instr_pc, input instr_ready);
    modport slave  (input instr_valid, instruction, instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_reg != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time,
// buffers responses and streams them to decode; redirects flush the stream.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      imem,
    instr_if.master     dec,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t  state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic          push, pop, flush, valid;
    logic [CW-1:0] count, count_after_pop;
    fetch_entry_t  head, push_data;
    logic [31:0]   redirect_aligned;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    assign valid            = (count != '0);
    assign pop              = valid & dec.instr_ready;
    assign count_after_pop  = count - CW'(pop);
    assign redirect_aligned = word_align(redirect_pc);
    assign push_data        = {addr_reg, imem.imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (redirect_valid) begin
                    pc_next = redirect_aligned;
                    flush   = 1'b1;
                end else if (count_after_pop < DEPTH_C) begin
                    state_next = REQ;
                    addr_next  = pc_reg;
                end
            end
            REQ: begin
                // A request is never withdrawn: without an ack we must drain it in DROP.
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    flush      = 1'b1;
                    state_next = imem.imem_ack ? IDLE : DROP;
                end else if (imem.imem_ack) begin
                    push       = 1'b1;
                    pc_next    = pc_reg + INSTR_BYTES;
                    addr_next  = pc_reg + INSTR_BYTES;
                    state_next = (count_after_pop + CW'(1) < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) pc_next = redirect_aligned;
                if (imem.imem_ack)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem.imem_req   = (state_reg != IDLE);
    assign imem.imem_addr  = addr_reg;
    assign dec.instr_valid = valid;
    assign dec.instruction = valid ? head.instr : '0;
    assign dec.instr_pc    = valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bench-side memory answers requests while a
// scoreboard of expected {pc, instr} entries is checked against what decode sees.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;

    imem_if  m1 ();
    instr_if d1 ();
    imem_if  m2 ();
    instr_if d2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (m1),
        .dec            (d1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
        .clk            (clk),
        .rst            (rst2),
        .imem           (m2),
        .dec            (d2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    fetch_entry_t sb[$];
    fetch_entry_t sb2[$];
    logic [31:0]  exp_addr;
    bit           drop_pending;
    int           acks;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_5820;
            32'h0000_0004: return 32'h0400_6820;
            default:       return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of instance 1, entered and left on a falling edge.
    task automatic cyc(input bit ack_i, input bit ready_i, input bit redir_i, input logic [31:0] rpc);
        fetch_entry_t e;
        bit acc;
        acc = ack_i && (m1.imem_req === 1'b1);
        m1.imem_ack    = acc;
        m1.imem_rdata  = acc ? mem_word(m1.imem_addr) : 32'h0;
        d1.instr_ready = ready_i;
        redirect_valid = redir_i;
        redirect_pc    = rpc;
        #1;
        if (m1.imem_req === 1'b1 && !drop_pending) chk("imem_addr", m1.imem_addr, exp_addr);
        if (d1.instr_valid === 1'b1 && ready_i) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed instr_pc=%h expected no instruction", d1.instr_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("decode pc=%h instr=%h", d1.instr_pc, d1.instruction);
                chk("instr_pc", d1.instr_pc, e.pc);
                chk("instruction", d1.instruction, e.instr);
            end
        end
        if (redir_i) begin
            sb.delete();
            drop_pending = (m1.imem_req === 1'b1) && !acc;
            exp_addr = rpc & ~32'h3;
        end else if (acc) begin
            if (drop_pending) begin
                drop_pending = 1'b0;
            end else begin
                sb.push_back({exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
                acks++;
            end
        end
        @(negedge clk);
        m1.imem_ack    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m1.imem_ack    = 1'b0;
        d1.instr_ready = 1'b0;
        redirect_valid = 1'b0;
        sb.delete();
        exp_addr     = 32'h0;
        drop_pending = 1'b0;
        acks         = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        fetch_entry_t e2;
        logic [31:0]  exp2;
        int           n2;
        bit           a2;

        rst = 1'b1; rst2 = 1'b1;
        m1.imem_ack = 1'b0; m1.imem_rdata = 32'h0; d1.instr_ready = 1'b0;
        m2.imem_ack = 1'b0; m2.imem_rdata = 32'h0; d2.instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        redirect_valid2 = 1'b0; redirect_pc2 = 32'h0;
        exp_addr = 32'h0; drop_pending = 1'b0; acks = 0;

        @(negedge clk);
        chk("rst_req", m1.imem_req, 0);
        chk("rst_addr", m1.imem_addr, 32'h0);
        chk("rst_valid", d1.instr_valid, 0);
        chk("rst_instruction", d1.instruction, 32'h0);
        chk("rst_instr_pc", d1.instr_pc, 32'h0);
        chk("rst2_addr", m2.imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with immediate acks and a ready consumer.
        for (int i = 0; i < 20 && acks < 4; i++) cyc(1, 1, 0, 32'h0);
        chk("stream_acks", acks, 4);

        // Backpressure: only FIFO_DEPTH acks, then IDLE with head held.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 32'h0);
        chk("bp_acks", acks, 2);
        chk("bp_idle_req", m1.imem_req, 0);
        chk("bp_valid", d1.instr_valid, 1);
        chk("bp_hold_pc", d1.instr_pc, 32'h0);
        chk("bp_hold_instr", d1.instruction, 32'h0000_5820);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'h0);
        chk("bp_resume_acks", acks, 5);

        // Ack delayed five cycles.
        do_reset();
        cyc(0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("dly_req", m1.imem_req, 1);
            chk("dly_addr", m1.imem_addr, 32'h0);
            chk("dly_valid", d1.instr_valid, 0);
            cyc(0, 1, 0, 32'h0);
        end
        cyc(1, 1, 0, 32'h0);
        chk("dly_lat_valid", d1.instr_valid, 1);
        chk("dly_lat_pc", d1.instr_pc, 32'h0);
        cyc(0, 1, 0, 32'h0);

        // Redirect while the request at 8 is outstanding.
        do_reset();
        for (int i = 0; i < 10 && acks < 2; i++) cyc(1, 1, 0, 32'h0);
        chk("rd_pending_addr", m1.imem_addr, 32'h8);
        cyc(0, 0, 1, 32'h100);
        chk("rd_drop_req", m1.imem_req, 1);
        chk("rd_drop_addr", m1.imem_addr, 32'h8);
        chk("rd_flush_valid", d1.instr_valid, 0);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        chk("rd_dropped_valid", d1.instr_valid, 0);
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        chk("rd_first_valid", d1.instr_valid, 1);
        chk("rd_first_pc", d1.instr_pc, 32'h100);
        cyc(1, 1, 0, 32'h0);

        // Redirect coincident with the ack at 4, unaligned target.
        do_reset();
        for (int i = 0; i < 10 && acks < 1; i++) cyc(1, 1, 0, 32'h0);
        chk("co_req", m1.imem_req, 1);
        chk("co_addr", m1.imem_addr, 32'h4);
        cyc(1, 1, 1, 32'h203);
        chk("co_lat1_valid", d1.instr_valid, 0);
        chk("co_lat1_req", m1.imem_req, 0);
        cyc(1, 1, 0, 32'h0);
        chk("co_lat2_valid", d1.instr_valid, 0);
        chk("co_aligned_addr", m1.imem_addr, 32'h200);
        cyc(1, 1, 0, 32'h0);
        chk("co_lat3_valid", d1.instr_valid, 1);
        chk("co_first_pc", d1.instr_pc, 32'h200);
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);

        // Second instance: PC wrap past 32'hFFFF_FFFC, then async reset mid-request.
        rst2 = 1'b0;
        d2.instr_ready = 1'b1;
        exp2 = 32'hFFFF_FFF8;
        n2 = 0;
        for (int i = 0; i < 20 && (n2 < 3 || sb2.size() != 0); i++) begin
            a2 = (m2.imem_req === 1'b1) && (n2 < 3);
            m2.imem_ack   = a2;
            m2.imem_rdata = mem_word(m2.imem_addr);
            #1;
            if (d2.instr_valid === 1'b1) begin
                checks++;
                assert (sb2.size() != 0) else begin
                    errors++;
                    $error("FAIL wrap_unexpected observed instr_pc=%h expected no instruction", d2.instr_pc);
                end
                if (sb2.size() != 0) begin
                    e2 = sb2.pop_front();
                    $display("decode2 pc=%h instr=%h", d2.instr_pc, d2.instruction);
                    chk("wrap_pc", d2.instr_pc, e2.pc);
                    chk("wrap_instr", d2.instruction, e2.instr);
                end
            end
            if (a2) begin
                chk("wrap_addr", m2.imem_addr, exp2);
                sb2.push_back({exp2, mem_word(exp2)});
                exp2 += 32'd4;
                n2++;
            end
            @(negedge clk);
        end
        m2.imem_ack = 1'b0;
        chk("wrap_acks", n2, 3);
        chk("wrap_drained", sb2.size(), 0);
        chk("pre_arst_req", m2.imem_req, 1);
        #2;
        rst2 = 1'b1;
        #1;
        chk("arst_req", m2.imem_req, 0);
        chk("arst_addr", m2.imem_addr, 32'hFFFF_FFF8);
        chk("arst_valid", d2.instr_valid, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the decode/control unit. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It buffers returned instructions in a small FIFO and presents them to decode over a valid/ready interface. Branch/jump redirects flush the buffer and discard any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, number of buffered instructions (power of two, >=2)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory, held until imem_ack
imem_addr  output  32  word-aligned fetch address, stable while imem_req=1
imem_ack  input  1  memory accepts request and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr_valid  output  1  instruction/instr_pc valid toward decode
instruction  output  32  instruction word to decode (opcode in [31:26])
instr_pc  output  32  PC of the presented instruction
instr_ready  input  1  decode consumes head entry when instr_valid & instr_ready
redirect_valid  input  1  one-cycle pulse: change fetch stream
redirect_pc  input  32  new PC; bits [1:0] ignored (forced to 0)

Behaviour:
- Reset (async assert): pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
- States: IDLE, REQ, DROP.
- IDLE: if FIFO has a free slot and no redirect this cycle -> REQ, imem_req=1, imem_addr=pc (registered; req visible the cycle after the decision).
- REQ: imem_req and imem_addr held stable until imem_ack. On ack: push {pc, imem_rdata}; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0). Then go to REQ again if a slot remains after the push/pop, else IDLE.
- Free-slot rule: count (after this cycle's pop) < FIFO_DEPTH. Only one request outstanding at a time, so a push never occurs into a full FIFO.
- Redirect in IDLE or REQ without ack this cycle:
  - pc<=redirect_pc&~3 and FIFO flushed (count=0, same-cycle pop ignored).
  - From REQ: go to DROP. imem_req stays 1 at the old address; a request is never withdrawn.
- Redirect coincident with ack in REQ: ack data discarded, no pc+4, pc<=redirect_pc, FIFO flushed, -> IDLE.
- DROP: wait for imem_ack, discard data, -> IDLE. A further redirect in DROP only updates pc.
- Decode side: instr_valid = (count!=0); instruction/instr_pc = head entry.
  - Pop on instr_valid & instr_ready.
  - Push+pop in the same cycle is allowed; count is unchanged.
- Latency: data acked at edge N is presented with instr_valid=1 from cycle N+1. Minimum redirect-to-new-instruction latency is 3 cycles.
- Outputs hold stable while instr_valid=1 and instr_ready=0.
- Reset mid-transaction: the request is dropped immediately; memory is responsible for ignoring the abandoned request.

Decomposition:
- fetch_pkg holds the state enum (IDLE/REQ/DROP), INSTR_BYTES=4 and the fetch entry struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO parameterised on depth.
  - Interface: push/pop/flush, count, head data.
  - Same-cycle push+pop supported; flush has priority over push and pop.

Test Plan:
- Reset release, imem_ack immediate, instr_ready=1 -> imem_addr sequence 0,4,8,12.
  - instruction matches rdata per address (e.g. 32'h0000_5820 at pc 0, 32'h0400_6820 at pc 4), each instr_pc correct.
- instr_ready=0 for 10 cycles -> exactly 2 acks accepted, then imem_req=0 (IDLE).
  - instr_valid held with pc 0 stable; on ready, pc 0 then 4 drain, fetch resumes at 8.
- Ack delayed 5 cycles -> imem_req and imem_addr stable for all 5 cycles, instr_valid low until the cycle after ack.
- redirect_pc=32'h100 while REQ at addr 8 outstanding, ack 3 cycles later -> FIFO flushed, that data is never presented.
  - Next imem_addr=32'h100, first output instr_pc=32'h100.
- Redirect coincident with ack at addr 4 -> addr-4 data dropped, next fetch at redirect_pc.
  - Redirect 32'h203 yields addr 32'h200.
- RESET_PC=32'hFFFF_FFF8, continuous ready -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Async rst mid-REQ -> imem_req=0 with no clock edge.
